// File: rtl/dsp_pkg.sv
// dsp_pkg: shared definitions for the DSP multiply-accumulate pipeline.
//   OP_MAC    (00): P = A*B + C + CARRYIN
//   OP_PREADD (01): P = (D+A)*B + CARRYIN
//   OP_ACC    (10): P = P + A*B + CARRYIN
//   OP_PRESUB (11): P = C - (D-A)*B + CARRYIN
package dsp_pkg;

    localparam logic [1:0] OP_MAC    = 2'b00;
    localparam logic [1:0] OP_PREADD = 2'b01;
    localparam logic [1:0] OP_ACC    = 2'b10;
    localparam logic [1:0] OP_PRESUB = 2'b11;

endpackage

// File: rtl/dsp_premult.sv
// dsp_premult: combinational pre-adder / pre-subtracter followed by a signed
// multiplier. This is the S2 datapath of dsp_mac_pipe.
// Ports:
//   sel  [1:0]        operation select (dsp_pkg encodings)
//   a    [AW-1:0]     signed operand
//   d    [AW-1:0]     signed pre-adder operand
//   b    [BW-1:0]     signed multiplier operand
//   prod [AW+BW:0]    signed product of the (AW+1)-bit pre-adder result and b
module dsp_premult
    import dsp_pkg::*;
#(
    parameter int AW = 18,
    parameter int BW = 18
) (
    input  logic [1:0]           sel,
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] d,
    input  logic signed [BW-1:0] b,
    output logic signed [AW+BW:0] prod
);

    logic signed [AW:0]    a_x;
    logic signed [AW:0]    d_x;
    logic signed [AW:0]    pre;
    logic signed [AW+BW:0] pre_x;
    logic signed [AW+BW:0] b_x;

    // One guard bit on the pre-adder so D+A / D-A can never wrap.
    assign a_x = {a[AW-1], a};
    assign d_x = {d[AW-1], d};

    always_comb begin
        pre = a_x;
        case (sel)
            OP_PREADD: pre = d_x + a_x;
            OP_PRESUB: pre = d_x - a_x;
            default:   pre = a_x;
        endcase
    end

    // Operands are sign-extended to the full product width so the multiply
    // is evaluated at AW+BW+1 bits with no width ambiguity.
    assign pre_x = {{BW{pre[AW]}}, pre};
    assign b_x   = {{(AW+1){b[BW-1]}}, b};
    assign prod  = pre_x * b_x;

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: three-stage signed multiply-accumulate pipeline.
//   S1 registers all inputs, S2 registers pre-add + product, S3 performs the
//   post-add into the P accumulator with sticky signed-overflow detection.
// Handshake: in_valid qualifies A/B/C/D/CARRYIN/sel in the cycle it is high
// and the pipeline accepts it on every ce-enabled edge (no backpressure);
// out_valid is high for exactly one cycle per result, in the cycle P holds it.
// Ports:
//   clk, rst (sync, active-high), ce (clock enable), clr (clear P and ovf)
//   in_valid, A[AW], B[BW], C[PW], D[AW], CARRYIN, sel[2]
//   P[PW] result/accumulator, out_valid, ovf (sticky overflow)
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int AW = 18,
    parameter int BW = 18,
    parameter int PW = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [AW-1:0] A,
    input  logic signed [BW-1:0] B,
    input  logic signed [PW-1:0] C,
    input  logic signed [AW-1:0] D,
    input  logic                 CARRYIN,
    input  logic [1:0]           sel,
    output logic signed [PW-1:0] P,
    output logic                 out_valid,
    output logic                 ovf
);

    localparam int MW = AW + BW + 1;

    // The product must fit inside P, otherwise sign extension to PW+1 bits
    // below would be a truncation.
    if (MW > PW) begin : g_width_check
        $error("dsp_mac_pipe: AW+BW+1 must not exceed PW");
    end

    // ---------------- S1: input registers ----------------
    logic                 s1_valid;
    logic signed [AW-1:0] s1_a;
    logic signed [BW-1:0] s1_b;
    logic signed [PW-1:0] s1_c;
    logic signed [AW-1:0] s1_d;
    logic                 s1_cin;
    logic [1:0]           s1_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (ce) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            s1_a   <= A;
            s1_b   <= B;
            s1_c   <= C;
            s1_d   <= D;
            s1_cin <= CARRYIN;
            s1_sel <= sel;
        end
    end

    // ---------------- S2: pre-add and multiply ----------------
    logic signed [MW-1:0] prod_c;

    dsp_premult #(
        .AW (AW),
        .BW (BW)
    ) u_premult (
        .sel  (s1_sel),
        .a    (s1_a),
        .d    (s1_d),
        .b    (s1_b),
        .prod (prod_c)
    );

    logic                 s2_valid;
    logic signed [MW-1:0] s2_prod;
    logic signed [PW-1:0] s2_c;
    logic                 s2_cin;
    logic [1:0]           s2_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (ce) begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            s2_prod <= prod_c;
            s2_c    <= s1_c;
            s2_cin  <= s1_cin;
            s2_sel  <= s1_sel;
        end
    end

    // ---------------- S3: post-add into P ----------------
    // All terms carried at PW+1 bits; the extra bit exposes signed overflow.
    logic signed [PW:0] prod_x;
    logic signed [PW:0] c_x;
    logic signed [PW:0] p_x;
    logic        [PW:0] cin_x;
    logic signed [PW:0] sum;
    logic               sum_ovf;

    assign prod_x = {{(PW + 1 - MW){s2_prod[MW-1]}}, s2_prod};
    assign c_x    = {s2_c[PW-1], s2_c};
    assign p_x    = {P[PW-1], P};
    assign cin_x  = {{PW{1'b0}}, s2_cin};

    // The accumulate path reads P directly, so back-to-back OP_ACC results
    // chain through the register written on the previous edge.
    always_comb begin
        sum = c_x + prod_x + cin_x;
        case (s2_sel)
            OP_MAC:    sum = c_x + prod_x + cin_x;
            OP_PREADD: sum = prod_x + cin_x;
            OP_ACC:    sum = p_x + prod_x + cin_x;
            OP_PRESUB: sum = c_x - prod_x + cin_x;
            default:   sum = c_x + prod_x + cin_x;
        endcase
    end

    // Not representable in PW signed bits when the top two bits disagree.
    assign sum_ovf = sum[PW] ^ sum[PW-1];

    // clr wins over a result arriving in the same cycle; S1/S2 keep moving.
    always_ff @(posedge clk) begin
        if (rst) begin
            P         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            P         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                P   <= sum[PW-1:0];
                ovf <= ovf | sum_ovf;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed-vector bench for dsp_mac_pipe with a scoreboard.
// Drivers push the hand-computed P/ovf and the enabled-edge count at which the
// result is due; a negedge monitor pops and compares on every out_valid.
module tb_dsp_mac_pipe;
    import dsp_pkg::*;

    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 48;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic                 ce = 1'b1;
    logic                 clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [AW-1:0] a = '0;
    logic signed [BW-1:0] b = '0;
    logic signed [PW-1:0] c = '0;
    logic signed [AW-1:0] d = '0;
    logic                 cin = 1'b0;
    logic [1:0]           sel = OP_MAC;
    logic signed [PW-1:0] p;
    logic                 out_valid;
    logic                 ovf;

    dsp_mac_pipe #(
        .AW (AW),
        .BW (BW),
        .PW (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .clr       (clr),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .C         (c),
        .D         (d),
        .CARRYIN   (cin),
        .sel       (sel),
        .P         (p),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    // Count of ce-enabled, non-reset edges: the bench's own latency reference.
    int en_cnt = 0;
    always @(posedge clk) if (ce && !rst) en_cnt <= en_cnt + 1;

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    logic          exp_ovf_q[$];
    int            exp_cyc_q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic check_val(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [PW-1:0] m_p;
    logic          m_o;
    int            m_c;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got P=0x%0h expected no output", p);
            end else begin
                m_p = exp_q.pop_front();
                m_o = exp_ovf_q.pop_front();
                m_c = exp_cyc_q.pop_front();
                check_val("result_p", p, m_p);
                check_bit("result_ovf", ovf, m_o);
                check_int("result_latency", en_cnt, m_c);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic signed [AW-1:0] ta,
                         input logic signed [BW-1:0] tb_v, input logic signed [PW-1:0] tc,
                         input logic signed [AW-1:0] td, input logic tcin,
                         input logic push, input logic [PW-1:0] ep, input logic eo);
        @(negedge clk);
        in_valid = 1'b1;
        sel      = op;
        a        = ta;
        b        = tb_v;
        c        = tc;
        d        = td;
        cin      = tcin;
        if (push) begin
            exp_q.push_back(ep);
            exp_ovf_q.push_back(eo);
            exp_cyc_q.push_back(en_cnt + 3);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        check_val("clr_p", p, '0);
        check_bit("clr_ovf", ovf, 1'b0);
        check_bit("clr_out_valid", out_valid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    int guard;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_val("reset_p", p, '0);
        check_bit("reset_ovf", ovf, 1'b0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_bit("post_reset_out_valid", out_valid, 1'b0);

        // Mode 00: 11*3 + 1 = 34
        issue(OP_MAC, 11, 3, 1, 0, 1'b0, 1'b1, 48'd34, 1'b0);
        idle(5);

        // Mode 01 then 11: (3+11)*3 = 42 ; 1 - (3-11)*3 = 25
        issue(OP_PREADD, 11, 3, 1, 3, 1'b0, 1'b1, 48'd42, 1'b0);
        issue(OP_PRESUB, 11, 3, 1, 3, 1'b0, 1'b1, 48'd25, 1'b0);
        // Signed operands with carry: (-20+5)*7 + 1 = -104 ; 100 - (-2-5)*(-4) + 1 = 73
        issue(OP_PREADD, 5, 7, 0, -18'sd20, 1'b1, 1'b1, -48'sd104, 1'b0);
        issue(OP_PRESUB, 5, -18'sd4, 100, -18'sd2, 1'b1, 1'b1, 48'd73, 1'b0);
        idle(5);

        // Mode 10 after rst: 33+1 per step
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(OP_ACC, 11, 3, 0, 0, 1'b1, 1'b1, 48'd34, 1'b0);
        issue(OP_ACC, 11, 3, 0, 0, 1'b1, 1'b1, 48'd68, 1'b0);
        issue(OP_ACC, 11, 3, 0, 0, 1'b1, 1'b1, 48'd102, 1'b0);
        issue(OP_ACC, 11, 3, 0, 0, 1'b1, 1'b1, 48'd136, 1'b0);
        idle(5);
        pulse_clr();

        // Overflow, then a clean result with ovf still sticky
        issue(OP_MAC, 1, 1, 48'h7FFF_FFFF_FFFF, 0, 1'b0, 1'b1, 48'h8000_0000_0000, 1'b1);
        issue(OP_MAC, 2, 2, 0, 0, 1'b0, 1'b1, 48'd4, 1'b1);
        idle(5);
        check_bit("ovf_sticky", ovf, 1'b1);
        pulse_clr();

        // Stall: 3 ops, ce low for 5 edges, 3 more ops; all 6 in order
        issue(OP_MAC, 1, 5, 0, 0, 1'b0, 1'b1, 48'd5, 1'b0);
        issue(OP_MAC, 2, 5, 0, 0, 1'b0, 1'b1, 48'd10, 1'b0);
        issue(OP_MAC, 3, 5, 0, 0, 1'b0, 1'b1, 48'd15, 1'b0);
        @(negedge clk);
        ce       = 1'b0;
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_bit("stall_out_valid", out_valid, 1'b0);
        end
        ce = 1'b1;
        issue(OP_MAC, 4, 5, 0, 0, 1'b0, 1'b1, 48'd20, 1'b0);
        issue(OP_MAC, 5, 5, 0, 0, 1'b0, 1'b1, 48'd25, 1'b0);
        issue(OP_MAC, 6, 5, 0, 0, 1'b0, 1'b1, 48'd30, 1'b0);
        idle(6);

        // clr coincident with a result in S3: that result is dropped, the
        // following accumulate starts from the cleared P (0 + 2*3 = 6)
        issue(OP_MAC, 7, 1, 0, 0, 1'b0, 1'b0, '0, 1'b0);
        issue(OP_ACC, 2, 3, 0, 0, 1'b0, 1'b1, 48'd6, 1'b0);
        issue(OP_MAC, 4, 4, 0, 0, 1'b0, 1'b1, 48'd16, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        idle(5);

        // Reset with two operations in flight
        issue(OP_MAC, 9, 9, 0, 0, 1'b0, 1'b0, '0, 1'b0);
        issue(OP_MAC, 8, 8, 0, 0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_bit("flush_out_valid", out_valid, 1'b0);
            check_val("flush_p", p, '0);
        end

        // First op after reset still appears 3 enabled cycles later
        issue(OP_MAC, 3, 3, 0, 0, 1'b1, 1'b1, 48'd10, 1'b0);
        idle(1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_int("drain_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 Parameters SHALL be: AW, default 18, width of A and D; BW, default 18, width of B; PW, default 48, width of C and P.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ce  input  1  clock enable; when 0, every pipeline register SHALL hold.
REQ-005 clr  input  1  synchronous clear of the accumulator (P) and the overflow flag.
REQ-006 in_valid  input  1  qualifies A, B, C, D, CARRYIN and sel this cycle.
REQ-007 A  input  AW  signed operand.
REQ-008 B  input  BW  signed multiplier operand.
REQ-009 C  input  PW  signed addend.
REQ-010 D  input  AW  signed pre-adder operand.
REQ-011 CARRYIN  input  1  unsigned carry, added in every mode.
REQ-012 sel  input  2  operation select.
REQ-013 P  output  PW  signed result / accumulator register.
REQ-014 out_valid  output  1  P holds a new result this cycle.
REQ-015 ovf  output  1  sticky signed-overflow flag.

Function
REQ-016 Pipeline SHALL have 3 register stages: S1 registers all inputs plus in_valid; S2 computes the pre-add/pre-subtract and the product; S3 computes the post-add into P.
REQ-017 Latency SHALL be exactly 3 ce-enabled cycles from in_valid to out_valid, with throughput 1 result per enabled cycle.
REQ-018 sel=00: P = A*B + C + CARRYIN.
REQ-019 sel=01: P = (D+A)*B + CARRYIN; C is ignored.
REQ-020 sel=10: P = P + A*B + CARRYIN (accumulate). Back-to-back accumulates SHALL each use the immediately preceding P without bubbles.
REQ-021 sel=11: P = C - (D-A)*B + CARRYIN.
REQ-022 Pre-adder results SHALL be AW+1 bits and products AW+BW+1 bits, all sign-extended to PW+1 bits before the S3 add.
REQ-023 Elaboration SHALL fail if AW+BW+1 > PW.
REQ-024 P SHALL take the low PW bits of the S3 sum (two's-complement wrap).
REQ-025 ovf SHALL be set when the PW+1-bit S3 sum is not representable in PW signed bits, and SHALL remain set until rst or clr.
REQ-026 Stages whose valid bit is 0 SHALL NOT change P or ovf, and out_valid SHALL be 0 for that S3 cycle.
REQ-027 With ce=0, out_valid SHALL be 0; stage contents, P and ovf SHALL hold; clr and rst SHALL still act.
REQ-028 clr SHALL zero P and ovf on the next edge and force out_valid to 0. A result reaching S3 in the same cycle is discarded. S1 and S2 SHALL be unaffected.
REQ-029 sel changing between consecutive valid inputs SHALL take effect per operation, with no cross-operation hazard.

Reset
REQ-030 rst SHALL have priority over clr and ce.
REQ-031 On rst, all stage valid bits, out_valid, P and ovf SHALL be 0, and in-flight operations SHALL be discarded.
REQ-032 Data registers other than P need no reset value.
REQ-033 In the first cycle after rst deasserts, out_valid SHALL be 0. The first valid input SHALL appear at the output exactly 3 enabled cycles later.

Structure
REQ-034 The sel encodings (OP_MAC, OP_PREADD, OP_ACC, OP_PRESUB) SHALL live as localparams in a shared package, dsp_pkg.
REQ-035 The S2 pre-adder/multiplier SHALL be a sub-module named dsp_premult (combinational, parameterised AW/BW), instantiated once.

Verification
REQ-036 Mode 00: A=0x0000B, B=3, C=1, CARRYIN=0, one in_valid pulse -> P=34 with out_valid for exactly one cycle, 3 cycles later.
REQ-037 Mode 01 then mode 11 back-to-back: A=0xB, B=3, D=3, C=1 -> P=42, then P=25 on the next cycle.
REQ-038 Mode 10 after rst, 4 consecutive inputs with A=0xB, B=3, CARRYIN=1 -> P=34, 68, 102, 136 on consecutive cycles. Then clr -> P=0, ovf=0.
REQ-039 Mode 00: C=0x7FFF_FFFF_FFFF, A=1, B=1 -> P=0x8000_0000_0000 and ovf=1. ovf stays 1 through later non-overflowing results until clr.
REQ-040 Stall and reset: deassert ce for 5 cycles mid-stream -> no out_valid, and results resume in order with no loss or duplication. Assert rst with 2 operations in flight -> no out_valid after reset, and P=0.
